// File: rtl/noc_pkg.sv
// Shared NoC definitions: output-port codes, flit-type codes and route modes,
// used by the input controller, switch allocator and crossbar.
package noc_pkg;

  localparam int unsigned PORT_CODE_W = 3;
  localparam int unsigned FLIT_TYPE_W = 2;

  localparam logic [PORT_CODE_W-1:0] PORT_L    = 3'b000;
  localparam logic [PORT_CODE_W-1:0] PORT_E    = 3'b001;
  localparam logic [PORT_CODE_W-1:0] PORT_W    = 3'b010;
  localparam logic [PORT_CODE_W-1:0] PORT_N    = 3'b011;
  localparam logic [PORT_CODE_W-1:0] PORT_S    = 3'b100;
  localparam logic [PORT_CODE_W-1:0] PORT_NONE = 3'b111;

  localparam logic ROUTE_XY = 1'b0;
  localparam logic ROUTE_YX = 1'b1;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } ctrl_state_e;

  // A flit that opens a packet and therefore carries a destination.
  function automatic logic is_head(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/noc_route_calc.sv
// Dimension-order route computation: current and destination coordinates to
// output-port code, X-first or Y-first depending on mode.
module noc_route_calc
  import noc_pkg::*;
#(
  parameter int unsigned N_ADD      = 2,
  parameter int unsigned N_REGISTER = 3
) (
  input  logic [N_ADD-1:0]      x_cur,
  input  logic [N_ADD-1:0]      y_cur,
  input  logic [N_ADD-1:0]      x_des,
  input  logic [N_ADD-1:0]      y_des,
  input  logic                  mode,
  output logic [N_REGISTER-1:0] port_c
);

  logic [N_REGISTER-1:0] x_port;
  logic [N_REGISTER-1:0] y_port;
  logic [N_REGISTER-1:0] none_code;

  // Each dimension yields its own hop (or none); mode picks which one wins.
  always_comb begin
    none_code = N_REGISTER'(PORT_NONE);
    x_port    = none_code;
    y_port    = none_code;
    port_c    = N_REGISTER'(PORT_L);

    if (x_des > x_cur) begin
      x_port = N_REGISTER'(PORT_E);
    end else if (x_des < x_cur) begin
      x_port = N_REGISTER'(PORT_W);
    end

    if (y_des > y_cur) begin
      y_port = N_REGISTER'(PORT_N);
    end else if (y_des < y_cur) begin
      y_port = N_REGISTER'(PORT_S);
    end

    if (mode == ROUTE_YX) begin
      if (y_port != none_code) begin
        port_c = y_port;
      end else if (x_port != none_code) begin
        port_c = x_port;
      end
    end else begin
      if (x_port != none_code) begin
        port_c = x_port;
      end else if (y_port != none_code) begin
        port_c = y_port;
      end
    end
  end

endmodule

// File: rtl/input_route_ctrl.sv
// Wormhole router input-port controller: routes the head flit, holds the
// output-port request until the tail passes and registers forwarded flits.
module input_route_ctrl
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_ADD      = 2,
  parameter int unsigned N_REGISTER = 3,
  parameter int unsigned ROUTE_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_ADD-1:0]      X_cur,
  input  logic [N_ADD-1:0]      Y_cur,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  empty,
  output logic                  read,
  input  logic                  grant,
  output logic                  req,
  output logic [N_REGISTER-1:0] register,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  valid_out,
  output logic                  drop
);

  ctrl_state_e           state_q;
  ctrl_state_e           state_d;
  logic [N_ADD-1:0]      x_cur_q;
  logic [N_ADD-1:0]      y_cur_q;
  logic [N_REGISTER-1:0] route_q;
  logic [N_REGISTER-1:0] route_d;
  logic [N_REGISTER-1:0] route_c;
  flit_type_e            flit_type;
  logic                  pop;
  logic                  fwd;
  logic                  drop_d;

  assign flit_type = flit_type_e'(Data_in[DATA_WIDTH-1 -: FLIT_TYPE_W]);

  noc_route_calc #(
    .N_ADD      (N_ADD),
    .N_REGISTER (N_REGISTER)
  ) u_route_calc (
    .x_cur  (x_cur_q),
    .y_cur  (y_cur_q),
    .x_des  (Data_in[N_ADD-1:0]),
    .y_des  (Data_in[2*N_ADD-1:N_ADD]),
    .mode   (1'(ROUTE_MODE)),
    .port_c (route_c)
  );

  // Next-state, FIFO pop and forward/drop decisions.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    pop     = 1'b0;
    fwd     = 1'b0;
    drop_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (is_head(flit_type)) begin
            route_d = route_c;
            state_d = ST_REQ;
          end else begin
            // Body/tail with no open packet: discard it.
            pop    = 1'b1;
            drop_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (grant && !empty) begin
          pop     = 1'b1;
          fwd     = 1'b1;
          state_d = (flit_type == FLIT_SINGLE) ? ST_IDLE : ST_XFER;
        end
      end
      ST_XFER: begin
        if (grant && !empty) begin
          pop = 1'b1;
          fwd = 1'b1;
          if (flit_type == FLIT_TAIL) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign read = pop & rst_n;

  // Coordinates follow the strap inputs for as long as reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cur_q   <= X_cur;
      y_cur_q   <= Y_cur;
      state_q   <= ST_IDLE;
      route_q   <= N_REGISTER'(PORT_NONE);
      req       <= 1'b0;
      register  <= N_REGISTER'(PORT_NONE);
      Data_out  <= '0;
      valid_out <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state_q   <= state_d;
      route_q   <= route_d;
      req       <= (state_d != ST_IDLE);
      register  <= (state_d == ST_IDLE) ? N_REGISTER'(PORT_NONE) : route_d;
      valid_out <= fwd;
      drop      <= drop_d;
      if (fwd) begin
        Data_out <= Data_in;
      end
    end
  end

endmodule

// File: tb/tb_input_route_ctrl.sv
// Bench for input_route_ctrl: XY and YX instances share one FIFO model and
// grant, checked by directed scenarios and a randomized reference model.
module tb_input_route_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned NA = 2;
  localparam int unsigned NR = 3;
  localparam int unsigned PW = DW - 2 - 2*NA;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NA-1:0] x_cur_in;
  logic [NA-1:0] y_cur_in;
  logic [DW-1:0] data_in;
  logic          empty;
  logic          grant;

  logic          read_xy, req_xy, valid_xy, drop_xy;
  logic [NR-1:0] reg_xy;
  logic [DW-1:0] dout_xy;
  logic          read_yx, req_yx, valid_yx, drop_yx;
  logic [NR-1:0] reg_yx;
  logic [DW-1:0] dout_yx;

  logic          rd_xy, rd_yx;
  logic [DW-1:0] fifo[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  input_route_ctrl #(.DATA_WIDTH(DW), .N_ADD(NA), .N_REGISTER(NR), .ROUTE_MODE(0)) dut_xy (
    .clk(clk), .rst_n(rst_n), .X_cur(x_cur_in), .Y_cur(y_cur_in),
    .Data_in(data_in), .empty(empty), .read(read_xy), .grant(grant),
    .req(req_xy), .register(reg_xy), .Data_out(dout_xy),
    .valid_out(valid_xy), .drop(drop_xy)
  );

  input_route_ctrl #(.DATA_WIDTH(DW), .N_ADD(NA), .N_REGISTER(NR), .ROUTE_MODE(1)) dut_yx (
    .clk(clk), .rst_n(rst_n), .X_cur(x_cur_in), .Y_cur(y_cur_in),
    .Data_in(data_in), .empty(empty), .read(read_yx), .grant(grant),
    .req(req_yx), .register(reg_yx), .Data_out(dout_yx),
    .valid_out(valid_yx), .drop(drop_yx)
  );

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int xd, input int yd);
    logic [PW-1:0] pay;
    pay = PW'($urandom);
    return {t, pay, NA'(yd), NA'(xd)};
  endfunction

  // Reference route from coordinate differences.
  function automatic logic [2:0] exp_port(input int xc, input int yc, input int xd,
                                          input int yd, input bit yx);
    logic [2:0] px, py;
    px = (xd > xc) ? 3'b001 : (xd < xc) ? 3'b010 : 3'b111;
    py = (yd > yc) ? 3'b011 : (yd < yc) ? 3'b100 : 3'b111;
    if (yx) return (py != 3'b111) ? py : (px != 3'b111) ? px : 3'b000;
    return (px != 3'b111) ? px : (py != 3'b111) ? py : 3'b000;
  endfunction

  task automatic do_reset(input int xc, input int yc);
    rst_n    = 1'b0;
    empty    = 1'b1;
    grant    = 1'b0;
    data_in  = '0;
    x_cur_in = NA'(xc);
    y_cur_in = NA'(yc);
    fifo.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: present FIFO head and grant, capture read, pop, sample after edge.
  task automatic tick(input logic g);
    @(negedge clk);
    grant   = g;
    empty   = (fifo.size() == 0);
    data_in = empty ? DW'($urandom) : fifo[0];
    #1;
    rd_xy = read_xy;
    rd_yx = read_yx;
    @(posedge clk);
    if (rd_xy && fifo.size() > 0) void'(fifo.pop_front());
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    x_cur_in = 2'd1;
    y_cur_in = 2'd1;
    grant    = 1'b1;
    empty    = 1'b0;
    data_in  = mk(T_BODY, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (read_xy !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %0b want 0", read_xy); end
    n_tests++; if (req_xy !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", req_xy); end
    n_tests++; if (reg_xy !== 3'b111) begin n_fail++; $display("FAIL reset_register: got %0b want 111", reg_xy); end
    n_tests++; if (dout_xy !== '0) begin n_fail++; $display("FAIL reset_data_out: got %0h want 0", dout_xy); end
    n_tests++; if (valid_xy !== 1'b0 || drop_xy !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_drop: got valid=%0b drop=%0b want 0 0", valid_xy, drop_xy);
    end
    empty = 1'b1;
  endtask

  task automatic test_single_route;
    logic [DW-1:0] f;
    do_reset(1, 1);
    f = mk(T_SINGLE, 3, 0);
    fifo.push_back(f);
    tick(1'b1);
    n_tests++; if (rd_xy !== 1'b0) begin n_fail++; $display("FAIL single_no_pop_idle: got %0b want 0", rd_xy); end
    n_tests++; if (req_xy !== 1'b1 || req_yx !== 1'b1) begin
      n_fail++; $display("FAIL single_req: got %0b/%0b want 1/1", req_xy, req_yx);
    end
    n_tests++; if (reg_xy !== 3'b001) begin n_fail++; $display("FAIL single_reg_xy: got %0b want 001", reg_xy); end
    n_tests++; if (reg_yx !== 3'b100) begin n_fail++; $display("FAIL single_reg_yx: got %0b want 100", reg_yx); end
    tick(1'b1);
    n_tests++; if (rd_xy !== 1'b1 || rd_yx !== 1'b1) begin
      n_fail++; $display("FAIL single_pop: got %0b/%0b want 1/1", rd_xy, rd_yx);
    end
    n_tests++; if (valid_xy !== 1'b1 || dout_xy !== f) begin
      n_fail++; $display("FAIL single_out: got valid=%0b data=%0h want 1 %0h", valid_xy, dout_xy, f);
    end
    n_tests++; if (req_xy !== 1'b0 || reg_xy !== 3'b111) begin
      n_fail++; $display("FAIL single_idle: got req=%0b reg=%0b want 0 111", req_xy, reg_xy);
    end
    tick(1'b1);
    n_tests++; if (valid_xy !== 1'b0 || dout_xy !== f || rd_xy !== 1'b0) begin
      n_fail++; $display("FAIL single_hold: got valid=%0b data=%0h rd=%0b want 0 %0h 0", valid_xy, dout_xy, rd_xy, f);
    end
    fifo.push_back(mk(T_SINGLE, 1, 1));
    tick(1'b1);
    n_tests++; if (reg_xy !== 3'b000 || reg_yx !== 3'b000) begin
      n_fail++; $display("FAIL local_route: got %0b/%0b want 000/000", reg_xy, reg_yx);
    end
    tick(1'b1);
  endtask

  task automatic test_stall;
    logic [DW-1:0] pkt[4];
    logic [DW-1:0] got[$];
    do_reset(1, 1);
    pkt[0] = mk(T_HEAD, 0, 1);
    pkt[1] = mk(T_BODY, 0, 0);
    pkt[2] = mk(T_BODY, 2, 3);
    pkt[3] = mk(T_TAIL, 0, 0);
    foreach (pkt[i]) fifo.push_back(pkt[i]);
    tick(1'b1);
    tick(1'b1);
    if (valid_xy) got.push_back(dout_xy);
    for (int i = 0; i < 2; i++) begin
      tick(1'b0);
      n_tests++; if (rd_xy !== 1'b0 || valid_xy !== 1'b0) begin
        n_fail++; $display("FAIL stall_idle_%0d: got rd=%0b valid=%0b want 0 0", i, rd_xy, valid_xy);
      end
      n_tests++; if (req_xy !== 1'b1 || reg_xy !== 3'b010) begin
        n_fail++; $display("FAIL stall_hold_%0d: got req=%0b reg=%0b want 1 010", i, req_xy, reg_xy);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      if (valid_xy) got.push_back(dout_xy);
    end
    tick(1'b1);
    n_tests++; if (req_xy !== 1'b0 || reg_xy !== 3'b111 || valid_xy !== 1'b0) begin
      n_fail++; $display("FAIL stall_end: got req=%0b reg=%0b valid=%0b want 0 111 0", req_xy, reg_xy, valid_xy);
    end
    n_tests++; if (got.size() != 4) begin
      n_fail++; $display("FAIL stall_count: got %0d flits want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_tests++; if (got[i] !== pkt[i]) begin
        n_fail++; $display("FAIL stall_order_%0d: got %0h want %0h", i, got[i], pkt[i]);
      end
    end
  endtask

  task automatic test_orphan;
    do_reset(2, 2);
    fifo.push_back(mk(T_BODY, 1, 1));
    tick(1'b0);
    n_tests++; if (rd_xy !== 1'b1) begin n_fail++; $display("FAIL orphan_pop: got %0b want 1", rd_xy); end
    n_tests++; if (drop_xy !== 1'b1 || req_xy !== 1'b0 || valid_xy !== 1'b0) begin
      n_fail++; $display("FAIL orphan_drop: got drop=%0b req=%0b valid=%0b want 1 0 0", drop_xy, req_xy, valid_xy);
    end
    tick(1'b0);
    n_tests++; if (drop_xy !== 1'b0 || rd_xy !== 1'b0) begin
      n_fail++; $display("FAIL orphan_pulse: got drop=%0b rd=%0b want 0 0", drop_xy, rd_xy);
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1, 1);
    fifo.push_back(mk(T_HEAD, 3, 1));
    fifo.push_back(mk(T_BODY, 0, 0));
    fifo.push_back(mk(T_BODY, 0, 0));
    fifo.push_back(mk(T_TAIL, 0, 0));
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    n_tests++; if (req_xy !== 1'b1 || valid_xy !== 1'b1 || reg_xy !== 3'b001) begin
      n_fail++; $display("FAIL mid_pre: got req=%0b valid=%0b reg=%0b want 1 1 001", req_xy, valid_xy, reg_xy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++; if (req_xy !== 1'b0 || reg_xy !== 3'b111) begin
      n_fail++; $display("FAIL mid_reset_req: got req=%0b reg=%0b want 0 111", req_xy, reg_xy);
    end
    n_tests++; if (valid_xy !== 1'b0 || dout_xy !== '0 || read_xy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_out: got valid=%0b data=%0h rd=%0b want 0 0 0", valid_xy, dout_xy, read_xy);
    end
    empty = 1'b1;
    fifo.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [2:0] want[5];
    do_reset(1, 1);
    fifo.push_back(mk(T_HEAD, 0, 1));
    fifo.push_back(mk(T_TAIL, 0, 0));
    fifo.push_back(mk(T_SINGLE, 1, 3));
    want = '{3'b010, 3'b010, 3'b111, 3'b011, 3'b111};
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      n_tests++; if (reg_xy !== want[i] || reg_yx !== want[i]) begin
        n_fail++; $display("FAIL b2b_reg_%0d: got %0b/%0b want %0b", i, reg_xy, reg_yx, want[i]);
      end
    end
  endtask

  // Random traffic against a packet-level model of the controller.
  task automatic test_random;
    int         xc, yc, mode;
    logic [2:0] rt_xy, rt_yx;
    logic [DW-1:0] f;
    logic [1:0] t;
    logic       g, ne, er, ev, ed;
    mode = 0;
    xc = $urandom_range(0, 3);
    yc = $urandom_range(0, 3);
    do_reset(xc, yc);
    rt_xy = 3'b111;
    rt_yx = 3'b111;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if ($urandom_range(0, 2) != 0 && fifo.size() < 8)
        fifo.push_back(mk(2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3)));
      g  = ($urandom_range(0, 3) != 0);
      ne = (fifo.size() > 0);
      f  = ne ? fifo[0] : '0;
      t  = f[DW-1:DW-2];
      if (mode == 0) er = ne && (t == T_BODY || t == T_TAIL);
      else           er = g && ne;
      tick(g);
      n_tests++; if (rd_xy !== er || rd_yx !== er) begin
        n_fail++; $display("FAIL rand_read_%0d: got %0b/%0b want %0b", cyc, rd_xy, rd_yx, er);
      end
      ev = 1'b0;
      ed = 1'b0;
      if (mode == 0) begin
        if (ne && (t == T_HEAD || t == T_SINGLE)) begin
          mode  = 1;
          rt_xy = exp_port(xc, yc, int'(f[NA-1:0]), int'(f[2*NA-1:NA]), 1'b0);
          rt_yx = exp_port(xc, yc, int'(f[NA-1:0]), int'(f[2*NA-1:NA]), 1'b1);
        end else if (ne) begin
          ed = 1'b1;
        end
      end else if (er) begin
        ev = 1'b1;
        if (mode == 1) mode = (t == T_SINGLE) ? 0 : 2;
        else if (t == T_TAIL) mode = 0;
      end
      n_tests++; if (valid_xy !== ev || drop_xy !== ed) begin
        n_fail++; $display("FAIL rand_valid_drop_%0d: got %0b %0b want %0b %0b", cyc, valid_xy, drop_xy, ev, ed);
      end
      n_tests++; if (ev && (dout_xy !== f || dout_yx !== f)) begin
        n_fail++; $display("FAIL rand_data_%0d: got %0h/%0h want %0h", cyc, dout_xy, dout_yx, f);
      end
      n_tests++; if (req_xy !== (mode != 0) || req_yx !== (mode != 0)) begin
        n_fail++; $display("FAIL rand_req_%0d: got %0b/%0b want %0b", cyc, req_xy, req_yx, (mode != 0));
      end
      n_tests++; if (reg_xy !== ((mode == 0) ? 3'b111 : rt_xy) || reg_yx !== ((mode == 0) ? 3'b111 : rt_yx)) begin
        n_fail++; $display("FAIL rand_reg_%0d: got %0b/%0b want %0b/%0b", cyc, reg_xy, reg_yx,
                           (mode == 0) ? 3'b111 : rt_xy, (mode == 0) ? 3'b111 : rt_yx);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_route();
    test_stall();
    test_orphan();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
